// File: rtl/register_file_16.sv
// Sixteen-entry general-purpose register file with one-hot write/read selects,
// R0 base-address masking and a sticky flag for illegal multi-hot selects.
module register_file_16 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [15:0]      r_in,
    input  logic [15:0]      r_out,
    input  logic             ba_out,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_drive,
    output logic             sel_err
);

    logic [WIDTH-1:0] regs_q [16];
    logic             sel_err_q;
    logic             sel_err_d;
    logic             in_multi;
    logic             out_multi;
    logic             in_onehot;
    logic             out_onehot;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic is_multi(input logic [15:0] v);
        return (v & (v - 16'd1)) != 16'd0;
    endfunction

    always_comb begin
        in_multi   = is_multi(r_in);
        out_multi  = is_multi(r_out);
        in_onehot  = (r_in != 16'd0) && !in_multi;
        out_onehot = (r_out != 16'd0) && !out_multi;
        sel_err_d  = sel_err_q | in_multi | out_multi;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
            sel_err_q <= 1'b0;
        end else begin
            if (in_onehot) begin
                for (int i = 0; i < 16; i++) begin
                    if (r_in[i]) begin
                        regs_q[i] <= bus_in;
                    end
                end
            end
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        bus_out   = '0;
        bus_drive = out_onehot;
        if (out_onehot) begin
            for (int i = 0; i < 16; i++) begin
                if (r_out[i]) begin
                    bus_out = regs_q[i];
                end
            end
            // Base-address mode reads R0 as zero while still owning the bus.
            if (r_out[0] && ba_out) begin
                bus_out = '0;
            end
        end
    end

    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_register_file_16.sv
// Randomised scoreboard bench for register_file_16: stimulus pushes expected
// read results from a reference model, a negedge monitor pops and compares.
module tb_register_file_16;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             clr;
    logic [15:0]      r_in;
    logic [15:0]      r_out;
    logic             ba_out;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] bus_out;
    logic             bus_drive;
    logic             sel_err;

    register_file_16 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .r_in      (r_in),
        .r_out     (r_out),
        .ba_out    (ba_out),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_drive (bus_drive),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             drive;
        logic             err;
        string            name;
    } exp_t;

    exp_t             expq[$];
    logic [WIDTH-1:0] model [16];
    logic             model_err;
    int               checks;
    int               errors;

    // Reference: expected bus view for the current cycle, straight from the read rules.
    task automatic push_expect(input string name);
        exp_t e;
        int   idx;
        e.name  = name;
        e.err   = model_err;
        e.drive = ($countones(r_out) == 1);
        e.data  = '0;
        if (e.drive) begin
            idx = 0;
            for (int i = 0; i < 16; i++) begin
                if (r_out[i]) idx = i;
            end
            if (!(idx == 0 && ba_out)) e.data = model[idx];
        end
        expq.push_back(e);
    endtask

    // Drive one transfer step, record its expectation, then apply the edge to the model.
    task automatic step(input logic c, input logic [15:0] wi, input logic [15:0] ro,
                        input logic ba, input logic [WIDTH-1:0] d, input string name);
        int wcount;
        int widx;
        clr    = c;
        r_in   = wi;
        r_out  = ro;
        ba_out = ba;
        bus_in = d;
        push_expect(name);
        @(posedge clk);
        wcount = $countones(wi);
        widx   = 0;
        for (int i = 0; i < 16; i++) begin
            if (wi[i]) widx = i;
        end
        if (c) begin
            for (int i = 0; i < 16; i++) model[i] = '0;
            model_err = 1'b0;
        end else begin
            if (wcount == 1) model[widx] = d;
            if (wcount > 1 || $countones(ro) > 1) model_err = 1'b1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (bus_out !== e.data || bus_drive !== e.drive || sel_err !== e.err) begin
                errors++;
                $display("FAIL %s: bus_out=%h drive=%b sel_err=%b, expected bus_out=%h drive=%b sel_err=%b",
                         e.name, bus_out, bus_drive, sel_err, e.data, e.drive, e.err);
            end
        end
    end

    function automatic logic [15:0] rand_vec();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 16'd1 << $urandom_range(0, 15);
        if (r < 8) return 16'd0;
        return 16'($urandom);
    endfunction

    initial begin
        checks    = 0;
        errors    = 0;
        model_err = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        clr    = 1'b1;
        r_in   = '0;
        r_out  = '0;
        ba_out = 1'b0;
        bus_in = '0;
        @(posedge clk);
        #1;

        step(0, 16'h0000, 16'h0000, 0, 32'h0, "reset_idle");
        // Reset with a competing legal write in the same edge.
        step(0, 16'h0020, 16'h0000, 0, 32'hDEADBEEF, "preload_r5");
        step(0, 16'h0000, 16'h0020, 0, 32'h0, "r5_preloaded");
        step(1, 16'h0020, 16'h0000, 0, 32'h12345678, "clr_with_write");
        for (int i = 0; i < 16; i++) step(0, 16'h0, 16'd1 << i, 0, 32'h0, "after_clr_read");

        for (int i = 0; i < 16; i++) begin
            step(0, 16'd1 << i, 16'h0, 0, 32'h1000_0000 + i, "write_each");
            step(0, 16'h0, 16'd1 << i, 0, 32'h0, "read_each");
        end

        step(0, 16'h0001, 16'h0, 0, 32'h44, "write_r0");
        step(0, 16'h0002, 16'h0, 0, 32'h7, "write_r1");
        step(0, 16'h0, 16'h0001, 1, 32'h0, "r0_baout");
        step(0, 16'h0, 16'h0001, 0, 32'h0, "r0_plain");
        step(0, 16'h0, 16'h0002, 1, 32'h0, "r1_baout");

        step(0, 16'h0008, 16'h0, 0, 32'hA, "write_r3");
        step(0, 16'h0008, 16'h0008, 0, 32'hB, "r3_same_cycle");
        step(0, 16'h0, 16'h0008, 0, 32'h0, "r3_next");

        step(0, 16'h0002, 16'h0, 0, 32'h1, "set_r1");
        step(0, 16'h0004, 16'h0, 0, 32'h2, "set_r2");
        step(0, 16'h0006, 16'h0, 0, 32'hFFFFFFFF, "multi_write");
        step(0, 16'h0, 16'h0002, 0, 32'h0, "r1_kept");
        step(0, 16'h0, 16'h0004, 0, 32'h0, "r2_kept");
        step(0, 16'h0200, 16'h0, 0, 32'h55AA55AA, "write_while_err");
        step(0, 16'h0, 16'h0200, 0, 32'h0, "read_while_err");
        step(1, 16'h0, 16'h0, 0, 32'h0, "clr_err");
        step(0, 16'h0, 16'h0011, 0, 32'h0, "multi_read");
        step(0, 16'h0, 16'h0000, 0, 32'h0, "idle_read");
        step(0, 16'h0, 16'h0000, 0, 32'h0, "idle_read2");
        step(1, 16'h0, 16'h0, 0, 32'h0, "clr_again");

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), rand_vec(), rand_vec(), 1'($urandom),
                 $urandom, "random");
        end
        step(0, 16'h0, 16'h0, 0, 32'h0, "final");

        for (int n = 0; n < 4 && expq.size() > 0; n++) @(posedge clk);
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
